// File: rtl/count_sequencer_if.sv
// rtl/count_sequencer_if.sv - command, counter-control and status bundle for count_sequencer
interface count_sequencer_if #(
   parameter int WIDTH = 8
);
   logic             cmd_start;
   logic             cmd_stop;
   logic             cmd_load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] target;
   logic [WIDTH-1:0] count_in;
   logic             en;
   logic             ld;
   logic [WIDTH-1:0] v;
   logic             busy;
   logic             done;
   logic [2:0]       state;

   modport master (
      output cmd_start, cmd_stop, cmd_load, load_val, target, count_in,
      input  en, ld, v, busy, done, state
   );

   modport slave (
      input  cmd_start, cmd_stop, cmd_load, load_val, target, count_in,
      output en, ld, v, busy, done, state
   );
endinterface

// File: rtl/count_sequencer.sv
// rtl/count_sequencer.sv - FSM turning start/stop/load commands into prescaled counter en/ld strobes
// Define AUTO_RELOAD_EN to reload v and restart counting each time the target is reached.
module count_sequencer #(
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 4
) (
   input  logic             clk,
   input  logic             rst,
   count_sequencer_if.slave bus
);
   localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_RUN   = 3'd2,
      S_PAUSE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic [WIDTH-1:0] v_q, v_d;
   logic             reload_q, reload_d;
   logic             at_target;
   logic             tick;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         presc_q  <= '0;
         v_q      <= '0;
         reload_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         v_q      <= v_d;
         reload_q <= reload_d;
      end
   end

   assign at_target = (bus.count_in == bus.target);
   assign tick      = (presc_q == PRE_MAX);

   always_comb begin
      state_d  = state_q;
      presc_d  = presc_q;
      v_d      = v_q;
      reload_d = reload_q;
      if (state_q == S_LOAD) begin
         // reload_q marks a LOAD entered by reaching the target, which resumes counting
         reload_d = 1'b0;
         if (reload_q) begin
            state_d = S_RUN;
            presc_d = '0;
         end else begin
            state_d = S_IDLE;
         end
      end else if (bus.cmd_load) begin
         state_d  = S_LOAD;
         v_d      = bus.load_val;
         reload_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (bus.cmd_start) begin
                  state_d = S_RUN;
                  presc_d = '0;
               end
            end
            S_PAUSE: begin
               if (bus.cmd_start) begin
                  state_d = S_RUN;
               end
            end
            S_RUN: begin
               if (bus.cmd_stop) begin
                  state_d = S_PAUSE;
               end else if (at_target) begin
`ifdef AUTO_RELOAD_EN
                  state_d  = S_LOAD;
                  reload_d = 1'b1;
`else
                  state_d  = S_DONE;
`endif
               end else begin
                  presc_d = tick ? '0 : presc_q + 1'b1;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // en is gated by at_target so the counter can never step past the terminal count
   assign bus.en    = (state_q == S_RUN) && tick && !at_target;
   assign bus.ld    = (state_q == S_LOAD);
   assign bus.v     = v_q;
   assign bus.busy  = (state_q == S_RUN);
   assign bus.done  = (state_q == S_DONE) || ((state_q == S_LOAD) && reload_q);
   assign bus.state = state_q;
endmodule
